// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: request/response bundle between the MEM stage and
// the data-memory responder.
//   master : MEM stage, drives req_*, observes ready/response/stall
//   slave  : responder, drives req_ready, rsp_*, mem_stall
// Signals:
//   req_valid/req_we/req_addr/req_wdata  load/store request
//   req_ready                            request accepted this cycle
//   rsp_valid/rsp_rdata/rsp_err          one-cycle response, load data, error
//   mem_stall                            pipeline freeze while access pending
interface data_mem_responder_if #(
  parameter int WORD_LEN = 32
);
  logic                req_valid;
  logic                req_we;
  logic [WORD_LEN-1:0] req_addr;
  logic [WORD_LEN-1:0] req_wdata;
  logic                req_ready;
  logic                rsp_valid;
  logic [WORD_LEN-1:0] rsp_rdata;
  logic                rsp_err;
  logic                mem_stall;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_stall
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_stall
  );
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder: responder end of the MEM-stage data-memory interface.
// Accepts one word load/store at a time, holds it for WAIT_STATES cycles,
// then answers with a one-cycle rsp_valid pulse. mem_stall freezes the
// pipeline while a request is pending and drops in the response cycle.
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-low (storage is not cleared)
//   bus        data_mem_responder_if.slave (request / response / stall)
// Optional (macro DMEM_STATS_EN):
//   stat_clr                              zero all counters at next edge
//   stat_reads/stat_writes/stat_errors    16-bit saturating access counters
module data_mem_responder #(
  parameter int WORD_LEN    = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  data_mem_responder_if.slave   bus
`ifdef DMEM_STATS_EN
  ,
  input  logic                  stat_clr,
  output logic [15:0]           stat_reads,
  output logic [15:0]           stat_writes,
  output logic [15:0]           stat_errors
`endif
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  // Latched request: decode happens at accept so the wait states only
  // carry the outcome, not the raw address.
  typedef struct packed {
    logic                we;
    logic                err;
    logic [AW-1:0]       idx;
    logic [WORD_LEN-1:0] wdata;
  } req_t;

  state_t              state_q, state_d;
  req_t                req_q, req_in;
  logic [3:0]          cnt_q;
  logic [WORD_LEN-1:0] rdata_q;
  logic [WORD_LEN-1:0] offset;
  logic                accept;
  logic                in_resp;
  logic [WORD_LEN-1:0] mem [DEPTH_WORDS];

  // Address decode. An underflowing subtraction is caught by the
  // below-base term, so the range check never sees a wrapped offset.
  always_comb begin
    offset       = bus.req_addr - WORD_LEN'(BASE_ADDR);
    req_in.we    = bus.req_we;
    req_in.wdata = bus.req_wdata;
    req_in.idx   = offset[AW+1:2];
    req_in.err   = (bus.req_addr[1:0] != 2'b00)
                || (bus.req_addr < WORD_LEN'(BASE_ADDR))
                || ((offset >> 2) >= WORD_LEN'(DEPTH_WORDS));
  end

  // Next state
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: if (bus.req_valid) begin
        accept  = 1'b1;
        state_d = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
      end
      S_WAIT: if (cnt_q == 4'd1) state_d = S_RESP;
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs. ready/stall are masked while rst is low so the pipeline sees
  // a quiet interface for the whole reset window.
  always_comb begin
    in_resp       = (state_q == S_RESP);
    bus.req_ready = rst & accept;
    bus.mem_stall = rst & bus.req_valid & ~in_resp;
    bus.rsp_valid = in_resp;
    bus.rsp_err   = in_resp & req_q.err;
    bus.rsp_rdata = rdata_q;
    if (in_resp) begin
      if (req_q.err)     bus.rsp_rdata = '0;
      else if (!req_q.we) bus.rsp_rdata = mem[req_q.idx];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      req_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        req_q <= req_in;
        cnt_q <= 4'(WAIT_STATES);
      end else if (state_q == S_WAIT) begin
        cnt_q <= cnt_q - 4'd1;
      end
      // Hold whatever the response cycle presented until the next response.
      if (in_resp) rdata_q <= bus.rsp_rdata;
    end
  end

  // Storage has no reset; a reset edge landing on RESP suppresses the write.
  always_ff @(posedge clk) begin
    if (rst && in_resp && req_q.we && !req_q.err)
      mem[req_q.idx] <= req_q.wdata;
  end

`ifdef DMEM_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst || stat_clr) begin
      stat_reads  <= '0;
      stat_writes <= '0;
      stat_errors <= '0;
    end else if (in_resp) begin
      if (req_q.err) begin
        if (stat_errors != 16'hFFFF) stat_errors <= stat_errors + 16'd1;
      end else if (req_q.we) begin
        if (stat_writes != 16'hFFFF) stat_writes <= stat_writes + 16'd1;
      end else begin
        if (stat_reads != 16'hFFFF) stat_reads <= stat_reads + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: two responders (WAIT_STATES=2 and 0) share clock
// and reset; 'sel' routes the common request drive to one of them and
// muxes its outputs back. Expected values come from a word-addressed
// associative-array memory and per-access timing derived from WAIT_STATES.
module tb_data_mem_responder;
  localparam int WL    = 32;
  localparam int DEPTH = 1024;
  localparam int BASE  = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        v, we;
  logic [31:0] addr, wdata;
  bit          sel;
  bit          clr_in_resp;

  data_mem_responder_if #(.WORD_LEN(WL)) b0 ();
  data_mem_responder_if #(.WORD_LEN(WL)) b1 ();

  assign b0.req_valid = v & ~sel;
  assign b1.req_valid = v & sel;
  assign b0.req_we    = we;
  assign b1.req_we    = we;
  assign b0.req_addr  = addr;
  assign b1.req_addr  = addr;
  assign b0.req_wdata = wdata;
  assign b1.req_wdata = wdata;

  logic        ready_o, rv_o, err_o, stall_o;
  logic [31:0] rd_o;
  assign ready_o = sel ? b1.req_ready : b0.req_ready;
  assign rv_o    = sel ? b1.rsp_valid : b0.rsp_valid;
  assign err_o   = sel ? b1.rsp_err   : b0.rsp_err;
  assign stall_o = sel ? b1.mem_stall : b0.mem_stall;
  assign rd_o    = sel ? b1.rsp_rdata : b0.rsp_rdata;

`ifdef DMEM_STATS_EN
  logic        stat_clr;
  logic [15:0] sr0, sw0, se0, sr1, sw1, se1;
`endif

  data_mem_responder #(.WORD_LEN(WL), .DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(2)) dut0 (
    .clk(clk), .rst(rst), .bus(b0)
`ifdef DMEM_STATS_EN
    , .stat_clr(stat_clr), .stat_reads(sr0), .stat_writes(sw0), .stat_errors(se0)
`endif
  );

  data_mem_responder #(.WORD_LEN(WL), .DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(0)) dut1 (
    .clk(clk), .rst(rst), .bus(b1)
`ifdef DMEM_STATS_EN
    , .stat_clr(stat_clr), .stat_reads(sr1), .stat_writes(sw1), .stat_errors(se1)
`endif
  );

  int errors = 0;
  int checks = 0;
  logic [31:0] mdl [int];
  int unsigned wq0[$], wq1[$];
  int srd[2], swr[2], ser[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_err(input logic [31:0] a);
    return (a % 4 != 0) || (a < BASE) || (a >= BASE + 4 * DEPTH);
  endfunction

  function automatic int key(input bit s, input logic [31:0] a);
    return int'(s) * 8192 + int'((a - BASE) / 4);
  endfunction

  task automatic zero_stats();
    for (int i = 0; i < 2; i++) begin srd[i] = 0; swr[i] = 0; ser[i] = 0; end
  endtask

  task automatic chk_stats();
`ifdef DMEM_STATS_EN
    chk("stat_reads0",  32'(sr0), srd[0]);
    chk("stat_writes0", 32'(sw0), swr[0]);
    chk("stat_errors0", 32'(se0), ser[0]);
    chk("stat_reads1",  32'(sr1), srd[1]);
    chk("stat_writes1", 32'(sw1), swr[1]);
    chk("stat_errors1", 32'(se1), ser[1]);
`endif
  endtask

  // One access on the selected responder, checked cycle by cycle:
  // accept cycle, WAIT_STATES wait cycles, then the response cycle.
  task automatic access(input bit wi, input logic [31:0] a, input logic [31:0] d, input bit hold);
    bit e, known;
    int ws;
    e     = is_err(a);
    ws    = sel ? 0 : 2;
    known = !e && mdl.exists(key(sel, a));
    @(negedge clk); v = 1'b1; we = wi; addr = a; wdata = d; #1;
    chk("accept_ready", 32'(ready_o), 1);
    chk("accept_stall", 32'(stall_o), 1);
    chk("accept_rsp_valid", 32'(rv_o), 0);
    @(posedge clk); #1;
    // Request inputs are don't-care once accepted.
    addr = $urandom; wdata = $urandom; we = 1'($urandom_range(0, 1));
    if (!hold) v = 1'($urandom_range(0, 1));
    for (int i = 0; i < ws; i++) begin
      @(negedge clk); #1;
      chk("wait_ready", 32'(ready_o), 0);
      chk("wait_rsp_valid", 32'(rv_o), 0);
      chk("wait_stall", 32'(stall_o), 32'(v));
    end
    @(negedge clk);
    if (clr_in_resp) begin
`ifdef DMEM_STATS_EN
      stat_clr = 1'b1;
`endif
    end
    #1;
    chk("resp_valid", 32'(rv_o), 1);
    chk("resp_err", 32'(err_o), 32'(e));
    chk("resp_stall", 32'(stall_o), 0);
    chk("resp_ready", 32'(ready_o), 0);
    if (e) chk("resp_rdata_err", rd_o, 0);
    else if (!wi && known) chk("resp_rdata", rd_o, mdl[key(sel, a)]);
    if (!e && wi) begin
      mdl[key(sel, a)] = d;
      if (sel) wq1.push_back(a); else wq0.push_back(a);
    end
    if (clr_in_resp) zero_stats();
    else if (e) ser[sel]++;
    else if (wi) swr[sel]++;
    else srd[sel]++;
    @(posedge clk); #1;
`ifdef DMEM_STATS_EN
    stat_clr = 1'b0;
`endif
    if (!hold) v = 1'b0;
  endtask

  task automatic idle(input int n);
    @(negedge clk); v = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  initial begin
    logic [31:0] a, d;
    int k;
    rst = 1'b0; v = 1'b0; we = 1'b0; addr = '0; wdata = '0; sel = 1'b0; clr_in_resp = 1'b0;
`ifdef DMEM_STATS_EN
    stat_clr = 1'b0;
`endif
    zero_stats();
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s); #1;
      chk("rst_ready", 32'(ready_o), 0);
      chk("rst_rsp_valid", 32'(rv_o), 0);
      chk("rst_rdata", rd_o, 0);
      chk("rst_err", 32'(err_o), 0);
      chk("rst_stall", 32'(stall_o), 0);
    end
    chk_stats();
    sel = 1'b0;
    rst = 1'b1;
    idle(2);

    // Store then load at base, 2 wait states.
    access(1'b1, 32'd1024, 32'hDEADBEEF, 1'b1);
    idle(1);
    access(1'b0, 32'd1024, 32'h0, 1'b1);
    idle(1);

    // Zero wait states.
    sel = 1'b1;
    access(1'b1, 32'd1028, 32'h00000005, 1'b0);
    access(1'b0, 32'd1028, 32'h0, 1'b0);
    idle(1);

    // Address errors, no write.
    sel = 1'b0;
    access(1'b0, 32'd1026, 32'h0, 1'b0);
    access(1'b1, 32'd1000, 32'h1, 1'b0);
    access(1'b0, 32'd1024, 32'h0, 1'b0);
    access(1'b1, 32'(BASE + 4 * DEPTH), 32'h77, 1'b0);
    access(1'b0, 32'(BASE + 4 * DEPTH), 32'h0, 1'b0);
    access(1'b0, 32'(BASE + 4 * DEPTH - 4), 32'h0, 1'b0);
    sel = 1'b1;
    access(1'b0, 32'd1023, 32'h0, 1'b0);
    access(1'b0, 32'd1028, 32'h0, 1'b0);
    idle(1);

    // Reset during WAIT of a store: aborted, prior value survives.
    sel = 1'b0;
    access(1'b1, 32'd1032, 32'h11223344, 1'b0);
    @(negedge clk); v = 1'b1; we = 1'b1; addr = 32'd1032; wdata = 32'hA5A5A5A5;
    @(posedge clk); #1;
    @(negedge clk); rst = 1'b0; v = 1'b0;
    @(negedge clk); #1;
    zero_stats();
    chk("midrst_ready", 32'(ready_o), 0);
    chk("midrst_rsp_valid", 32'(rv_o), 0);
    chk("midrst_rdata", rd_o, 0);
    chk("midrst_err", 32'(err_o), 0);
    chk("midrst_stall", 32'(stall_o), 0);
    chk_stats();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      chk("postrst_no_rsp", 32'(rv_o), 0);
    end
    access(1'b0, 32'd1032, 32'h0, 1'b0);
    idle(1);

    // Back-to-back loads with req_valid held high.
    access(1'b0, 32'd1024, 32'h0, 1'b1);
    access(1'b0, 32'd1032, 32'h0, 1'b1);
    idle(1);

`ifdef DMEM_STATS_EN
    @(negedge clk); stat_clr = 1'b1;
    @(posedge clk); #1; stat_clr = 1'b0;
    zero_stats();
    sel = 1'b0;
    access(1'b0, 32'd1024, 32'h0, 1'b0);
    access(1'b0, 32'd1032, 32'h0, 1'b0);
    access(1'b0, 32'd1024, 32'h0, 1'b0);
    access(1'b1, 32'd1036, 32'h36, 1'b0);
    access(1'b1, 32'd1040, 32'h40, 1'b0);
    access(1'b0, 32'd1026, 32'h0, 1'b0);
    @(negedge clk); #1;
    chk("stats_reads_abs", 32'(sr0), 3);
    chk("stats_writes_abs", 32'(sw0), 2);
    chk("stats_errors_abs", 32'(se0), 1);
    clr_in_resp = 1'b1;
    access(1'b0, 32'd1024, 32'h0, 1'b0);
    clr_in_resp = 1'b0;
    @(negedge clk); #1;
    chk_stats();
`endif

    // Random mix against the reference model.
    for (int i = 0; i < 40; i++) begin
      sel = 1'($urandom_range(0, 1));
      k = $urandom_range(0, 5);
      d = $urandom;
      case (k)
        0, 1: access(1'b1, 32'(BASE + 4 * $urandom_range(0, DEPTH - 1)), d, 1'($urandom_range(0, 1)));
        2, 3: begin
          if (sel && wq1.size() > 0)       a = wq1[$urandom_range(0, wq1.size() - 1)];
          else if (!sel && wq0.size() > 0) a = wq0[$urandom_range(0, wq0.size() - 1)];
          else                             a = 32'(BASE);
          access(1'b0, a, d, 1'($urandom_range(0, 1)));
        end
        4: begin
          case ($urandom_range(0, 2))
            0:       a = 32'(BASE + 4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3));
            1:       a = 32'($urandom_range(0, BASE - 1));
            default: a = 32'(BASE + 4 * DEPTH) + 32'($urandom_range(0, 4096));
          endcase
          access(1'($urandom_range(0, 1)), a, d, 1'b0);
        end
        default: begin
          if (sel && wq1.size() > 0)       a = wq1[wq1.size() - 1];
          else if (!sel && wq0.size() > 0) a = wq0[wq0.size() - 1];
          else                             a = 32'(BASE);
          access(1'b0, a, d, 1'b0);
        end
      endcase
    end
    idle(2);
    @(negedge clk); #1;
    chk("final_stall", 32'(stall_o), 0);
    chk_stats();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
